// File: rtl/srr_chain_walker.sv
// rtl/srr_chain_walker.sv - walks SRR entries and their per-request link lists, emitting request IDs
module srr_chain_walker #(
    parameter int SRR_ID_W = 4,
    parameter int REQ_ID_W = 8,
    parameter int TAG_W    = 12,
    parameter int MAX_HOPS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [SRR_ID_W-1:0]          start_srr,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         err_loop,
    output logic [SRR_ID_W-1:0]          srr_rd_addr,
    input  logic [TAG_W-1:0]             srr_rd_hit_tag,
    input  logic [REQ_ID_W-1:0]          srr_rd_count,
    input  logic [REQ_ID_W-1:0]          srr_rd_head_req,
    input  logic [SRR_ID_W-1:0]          srr_rd_chain_next,
    input  logic                         srr_rd_chain_valid,
    output logic [REQ_ID_W-1:0]          link_rd_addr,
    input  logic [REQ_ID_W-1:0]          link_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REQ_ID_W-1:0]          out_req_id,
    output logic [TAG_W-1:0]             out_hit_tag,
    output logic                         out_first,
    output logic                         out_last,
    output logic [REQ_ID_W+SRR_ID_W-1:0] emitted_cnt
);
    localparam int CNT_W = REQ_ID_W + SRR_ID_W;
    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_EMIT, S_LINK, S_NEXT, S_FIN
    } state_t;

    state_t              state, state_nxt;
    logic [TAG_W-1:0]    tag_q;
    logic [SRR_ID_W-1:0] chain_next_q;
    logic                chain_valid_q;
    logic [REQ_ID_W-1:0] remaining;
    logic                first_q;
    logic [HOP_W-1:0]    hops;
    logic                loop_err;
    logic                handshake;
    logic                hop_limit;

    assign handshake = (state == S_EMIT) && out_ready;
    assign hop_limit = (hops == HOP_W'(MAX_HOPS));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (srr_rd_count == '0) ? S_NEXT : S_EMIT;
            S_EMIT:  if (out_ready) state_nxt = (remaining == REQ_ID_W'(1)) ? S_NEXT : S_LINK;
            S_LINK:  state_nxt = S_EMIT;
            S_NEXT:  state_nxt = (!chain_valid_q || hop_limit) ? S_FIN : S_FETCH;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        err_loop  = (state == S_FIN) && loop_err;
        out_valid = (state == S_EMIT);
        out_first = out_valid && first_q;
        out_last  = out_valid && (remaining == REQ_ID_W'(1));
    end

    // link_rd_addr doubles as the current request ID presented downstream
    assign out_req_id  = link_rd_addr;
    assign out_hit_tag = tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            srr_rd_addr   <= '0;
            link_rd_addr  <= '0;
            tag_q         <= '0;
            chain_next_q  <= '0;
            chain_valid_q <= 1'b0;
            remaining     <= '0;
            first_q       <= 1'b0;
            hops          <= '0;
            loop_err      <= 1'b0;
            emitted_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) emitted_cnt <= emitted_cnt + CNT_W'(1);
            unique case (state)
                S_IDLE: if (start) begin
                    srr_rd_addr <= start_srr;
                    hops        <= HOP_W'(1);
                    emitted_cnt <= '0;
                    loop_err    <= 1'b0;
                end
                S_LOAD: begin
                    tag_q         <= srr_rd_hit_tag;
                    chain_next_q  <= srr_rd_chain_next;
                    chain_valid_q <= srr_rd_chain_valid;
                    remaining     <= srr_rd_count;
                    link_rd_addr  <= srr_rd_head_req;
                    first_q       <= 1'b1;
                end
                S_EMIT: if (out_ready) begin
                    remaining <= remaining - REQ_ID_W'(1);
                    first_q   <= 1'b0;
                end
                S_LINK: link_rd_addr <= link_rd_data;
                S_NEXT: if (chain_valid_q) begin
                    if (hop_limit) begin
                        loop_err <= 1'b1;
                    end else begin
                        srr_rd_addr <= chain_next_q;
                        hops        <= hops + HOP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_srr_chain_walker.sv
// tb/tb_srr_chain_walker.sv - randomized self-checking bench for srr_chain_walker
module tb_srr_chain_walker;
    localparam int SRR_ID_W = 4;
    localparam int REQ_ID_W = 6;
    localparam int TAG_W    = 12;
    localparam int MAX_HOPS = 4;
    localparam int CNT_W    = REQ_ID_W + SRR_ID_W;
    localparam int NSRR     = 1 << SRR_ID_W;
    localparam int NREQ     = 1 << REQ_ID_W;

    logic                clk = 1'b0;
    logic                rst, start, abort, out_ready;
    logic [SRR_ID_W-1:0] start_srr;
    logic                busy, done, err_loop;
    logic [SRR_ID_W-1:0] srr_rd_addr;
    logic [TAG_W-1:0]    srr_rd_hit_tag;
    logic [REQ_ID_W-1:0] srr_rd_count, srr_rd_head_req;
    logic [SRR_ID_W-1:0] srr_rd_chain_next;
    logic                srr_rd_chain_valid;
    logic [REQ_ID_W-1:0] link_rd_addr, link_rd_data;
    logic                out_valid, out_first, out_last;
    logic [REQ_ID_W-1:0] out_req_id;
    logic [TAG_W-1:0]    out_hit_tag;
    logic [CNT_W-1:0]    emitted_cnt;

    logic [TAG_W-1:0]    srr_tag  [NSRR];
    logic [REQ_ID_W-1:0] srr_cnt  [NSRR];
    logic [REQ_ID_W-1:0] srr_head [NSRR];
    logic [SRR_ID_W-1:0] srr_next [NSRR];
    logic                srr_val  [NSRR];
    logic [REQ_ID_W-1:0] link_mem [NREQ];

    int vectors = 0;
    int miscompares = 0;
    logic [TAG_W+REQ_ID_W+1:0] exp_q[$];
    bit exp_err;
    int exp_total;
    int hs_cyc[$];
    int done_cyc;
    int hs_total;

    always #5 clk = ~clk;

    srr_chain_walker #(
        .SRR_ID_W(SRR_ID_W), .REQ_ID_W(REQ_ID_W), .TAG_W(TAG_W), .MAX_HOPS(MAX_HOPS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_srr(start_srr), .abort(abort),
        .busy(busy), .done(done), .err_loop(err_loop),
        .srr_rd_addr(srr_rd_addr), .srr_rd_hit_tag(srr_rd_hit_tag),
        .srr_rd_count(srr_rd_count), .srr_rd_head_req(srr_rd_head_req),
        .srr_rd_chain_next(srr_rd_chain_next), .srr_rd_chain_valid(srr_rd_chain_valid),
        .link_rd_addr(link_rd_addr), .link_rd_data(link_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_req_id(out_req_id),
        .out_hit_tag(out_hit_tag), .out_first(out_first), .out_last(out_last),
        .emitted_cnt(emitted_cnt)
    );

    // Synchronous-read table models: data for an address appears the cycle after it is presented
    always @(posedge clk) begin
        srr_rd_hit_tag     <= srr_tag[srr_rd_addr];
        srr_rd_count       <= srr_cnt[srr_rd_addr];
        srr_rd_head_req    <= srr_head[srr_rd_addr];
        srr_rd_chain_next  <= srr_next[srr_rd_addr];
        srr_rd_chain_valid <= srr_val[srr_rd_addr];
        link_rd_data       <= link_mem[link_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tables();
        for (int e = 0; e < NSRR; e++) begin
            srr_tag[e] = '0; srr_cnt[e] = '0; srr_head[e] = '0; srr_next[e] = '0; srr_val[e] = 1'b0;
        end
        for (int r = 0; r < NREQ; r++) link_mem[r] = '0;
    endtask

    task automatic set_srr(input int e, input int tag, input int cnt, input int head,
                           input int nxt, input bit val);
        srr_tag[e]  = TAG_W'(tag);
        srr_cnt[e]  = REQ_ID_W'(cnt);
        srr_head[e] = REQ_ID_W'(head);
        srr_next[e] = SRR_ID_W'(nxt);
        srr_val[e]  = val;
    endtask

    // Expected output list for a whole walk, straight from the chain/link rules
    task automatic build_model(input int s);
        int e, n, visited;
        logic [REQ_ID_W-1:0] r;
        exp_q.delete();
        exp_err = 1'b0;
        e = s;
        visited = 0;
        while (1) begin
            visited++;
            n = int'(srr_cnt[e]);
            r = srr_head[e];
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({srr_tag[e], r, i == 0, i == n - 1});
                r = link_mem[r];
            end
            if (!srr_val[e]) break;
            if (visited == MAX_HOPS) begin
                exp_err = 1'b1;
                break;
            end
            e = int'(srr_next[e]);
        end
        exp_total = exp_q.size();
    endtask

    task automatic run_walk(input int s, input int rdy_pct, input int stall_from,
                            input int kill_cyc, input bit kill_rst);
        int cyc;
        bit fin, prev_stall;
        logic [REQ_ID_W-1:0] prev_id;
        logic [TAG_W+REQ_ID_W+1:0] e;
        build_model(s);
        hs_cyc.delete();
        done_cyc = -1;
        hs_total = 0;
        @(negedge clk);
        start = 1'b1;
        start_srr = SRR_ID_W'(s);
        @(negedge clk);
        start = 1'b0;
        start_srr = SRR_ID_W'($urandom);
        cyc = 1;
        fin = 1'b0;
        prev_stall = 1'b0;
        prev_id = '0;
        while (!fin && cyc < 2000) begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_id", 64'(out_req_id), 64'(prev_id));
            end
            if (done) begin
                done_cyc = cyc;
                check("err_loop", 64'(err_loop), 64'(exp_err));
                check("leftover", 64'(exp_q.size()), 64'd0);
                check("emitted_cnt", 64'(emitted_cnt), 64'(exp_total));
                fin = 1'b1;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (stall_from >= 0 && cyc >= stall_from && cyc < stall_from + 4) out_ready = 1'b0;
            if (kill_cyc == cyc && kill_rst) out_ready = 1'b0;
            if (out_valid && out_ready) begin
                hs_total++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("extra_req", 64'(out_req_id), 64'h3f3f);
                end else begin
                    e = exp_q.pop_front();
                    check("req", 64'({out_hit_tag, out_req_id, out_first, out_last}), 64'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_id = out_req_id;
            if (kill_cyc == cyc) begin
                if (kill_rst) rst = 1'b1; else abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                rst = 1'b0;
                out_ready = 1'b0;
                if (kill_rst)
                    check("rst_outputs", 64'({out_valid, busy, done, err_loop, out_first, out_last,
                          out_req_id, out_hit_tag, srr_rd_addr, link_rd_addr, emitted_cnt}), 64'd0);
                else begin
                    check("abort_idle", 64'({out_valid, busy, done}), 64'd0);
                    check("abort_cnt", 64'(emitted_cnt), 64'(hs_total));
                end
                return;
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) check("walk_timeout", 64'd0, 64'd1);
        out_ready = 1'b0;
        check("post_done", 64'({busy, done, err_loop}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; start_srr = '0;
        clear_tables();
        repeat (3) @(negedge clk);
        check("reset_state", 64'({out_valid, busy, done, err_loop, out_first, out_last,
              out_req_id, out_hit_tag, srr_rd_addr, link_rd_addr, emitted_cnt}), 64'd0);
        rst = 1'b0;

        // single entry, full throughput timing
        clear_tables();
        set_srr(2, 'h1A5, 3, 5, 0, 1'b0);
        link_mem[5] = 6'd9; link_mem[9] = 6'd12;
        run_walk(2, 100, -1, -1, 1'b0);
        check("t1_cyc0", 64'(hs_cyc[0]), 64'd3);
        check("t1_cyc1", 64'(hs_cyc[1]), 64'd5);
        check("t1_cyc2", 64'(hs_cyc[2]), 64'd7);
        check("t1_done", 64'(done_cyc), 64'd9);

        // backpressure on request 9
        run_walk(2, 100, 5, -1, 1'b0);
        check("bp_cyc1", 64'(hs_cyc[1]), 64'd9);
        check("bp_done", 64'(done_cyc), 64'd13);

        // abort in LINK, then a normal walk straight after
        run_walk(2, 100, -1, 4, 1'b0);
        run_walk(2, 100, -1, -1, 1'b0);
        check("post_abort_done", 64'(done_cyc), 64'd9);
        // abort coinciding with a handshake, and reset mid-EMIT
        run_walk(2, 100, -1, 5, 1'b0);
        check("abort_hs_cnt", 64'(hs_total), 64'd2);
        run_walk(2, 100, -1, 3, 1'b1);

        // two-entry chain
        clear_tables();
        set_srr(0, 'h011, 1, 4, 3, 1'b1);
        set_srr(3, 'h033, 2, 7, 0, 1'b0);
        link_mem[7] = 6'd8;
        run_walk(0, 100, -1, -1, 1'b0);
        check("chain_cyc1", 64'(hs_cyc[1]), 64'd7);

        // count zero skipped
        clear_tables();
        set_srr(1, 'h0AA, 0, 0, 2, 1'b1);
        set_srr(2, 'h0BB, 1, 6, 0, 1'b0);
        run_walk(1, 100, -1, -1, 1'b0);

        // loop guard 0->1->0
        clear_tables();
        set_srr(0, 'h100, 2, 1, 1, 1'b1);
        set_srr(1, 'h200, 1, 3, 0, 1'b1);
        link_mem[1] = 6'd2;
        run_walk(0, 70, -1, -1, 1'b0);
        check("loop_total", 64'(exp_total), 64'd6);

        for (int it = 0; it < 25; it++) begin
            for (int e = 0; e < NSRR; e++)
                set_srr(e, int'($urandom), int'($urandom_range(3)), int'($urandom),
                        int'($urandom), $urandom_range(9) < 7);
            for (int r = 0; r < NREQ; r++) link_mem[r] = REQ_ID_W'($urandom);
            run_walk(int'($urandom_range(NSRR - 1)), int'($urandom_range(100, 30)), -1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/srr_chain_walker.md
Name: srr_chain_walker

Overview:
- Drains the Same Row Request structure that the SRR table builds.
- Given a starting SRR entry, it reads that entry and walks the per-request link list from head for `count` requests, emitting one request ID per valid/ready handshake.
- It then follows `chain_next` to the next SRR entry until the chain ends.
- Sits between the SRR table / request link memory and the command-issue stage of the DRAM scheduler.

Parameters:
- SRR_ID_W, `SRR_ID_WIDTH: SRR entry index width.
- REQ_ID_W, `REQUEST_ID_WIDTH: request ID and count width.
- TAG_W, `HIT_TAG_WIDTH: hit tag width (bank_group, bank, row).
- MAX_HOPS, `MAX_SRR_ENTRIES: maximum SRR entries visited per walk; loop guard.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin walk; sampled only in IDLE
- start_srr  in  SRR_ID_W  first SRR entry of the walk
- abort  in  1  terminate walk
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the walk completes normally or on loop error
- err_loop  out  1  one-cycle pulse, coincident with done, when the MAX_HOPS guard trips
- srr_rd_addr  out  SRR_ID_W  registered SRR table read index; table data arrives the next cycle
- srr_rd_hit_tag  in  TAG_W  SRR table read data
- srr_rd_count  in  REQ_ID_W  SRR table read data
- srr_rd_head_req  in  REQ_ID_W  SRR table read data
- srr_rd_chain_next  in  SRR_ID_W  SRR table read data
- srr_rd_chain_valid  in  1  SRR table read data
- link_rd_addr  out  REQ_ID_W  registered request-link read index (current request); data arrives the next cycle
- link_rd_data  in  REQ_ID_W  next request ID in the same row
- out_valid  out  1  request available
- out_ready  in  1  downstream accepts
- out_req_id  out  REQ_ID_W  request ID
- out_hit_tag  out  TAG_W  row tag of the current SRR entry
- out_first  out  1  first request of this SRR entry
- out_last  out  1  last request of this SRR entry
- emitted_cnt  out  REQ_ID_W+SRR_ID_W  requests emitted in the current or last walk; cleared on start

Behaviour:
- Reset: all outputs and state registers go to 0; state is IDLE. Reset mid-walk discards everything with no done pulse.
- States: IDLE, FETCH, LOAD, EMIT, LINK, NEXT, FIN.
- IDLE:
  - start=1 sets srr_rd_addr=start_srr, hops=1, emitted_cnt=0, and moves to FETCH.
  - start is ignored in all other states.
- FETCH: srr_rd_addr is held stable for one cycle so the table samples it; go to LOAD.
- LOAD:
  - Capture tag, chain_next and chain_valid.
  - Set remaining = count, cur_req = link_rd_addr = head_req, first = 1.
  - If count == 0, go to NEXT (entry skipped, no output). Otherwise go to EMIT.
- EMIT:
  - out_valid = 1, out_req_id = cur_req, out_first = first, out_last = (remaining == 1).
  - Outputs are stable until out_ready=1.
  - On handshake: emitted_cnt++, remaining--, first = 0; if remaining was 1 go to NEXT, else go to LINK.
- LINK: cur_req = link_rd_addr = link_rd_data; return to EMIT. Sustained throughput is 1 request per 2 cycles.
- NEXT:
  - If chain_valid=0, go to FIN.
  - Else if hops == MAX_HOPS, go to FIN with err_loop flagged.
  - Else srr_rd_addr = chain_next, hops++, go to FETCH.
- FIN: done = 1 (and err_loop if flagged) for one cycle; go to IDLE. done and err_loop are registered and aligned.
- Latency: start seen at edge 0 gives FETCH in cycle 1, LOAD in cycle 2, and first out_valid in cycle 3. Each new chained entry costs 3 bubble cycles (NEXT, FETCH, LOAD).
- abort=1 in any non-IDLE state:
  - Next state is IDLE; out_valid deasserts the following cycle; no done pulse.
  - A handshake coinciding with abort still counts in emitted_cnt.
  - abort has priority over all other transitions; rst has priority over abort.
- out_valid is never withdrawn without a handshake, except on abort or rst.
- emitted_cnt wraps modulo 2^(REQ_ID_W+SRR_ID_W).
- The walker never writes either table.

Test Plan:
- Single entry: SRR 2 = {tag 0x1A5, count 3, head 5}, links 5→9, 9→12, no chain, out_ready=1 → out_req_id 5, 9, 12 at cycles 3, 5, 7; out_first on 5 only; out_last on 12 only; done at cycle 9; emitted_cnt=3.
- Chain: SRR 0 (count 1, head 4, next 3) → SRR 3 (count 2, head 7, link 7→8) → outputs 4, 7, 8 with tags switching at request 7; done pulses once; emitted_cnt=3.
- Backpressure: out_ready held low 4 cycles during EMIT of request 9 → out_valid, out_req_id=9 and out_last stay stable; no duplicate output; total count unchanged.
- Count zero: SRR 1 count=0 chained to SRR 2 (count 1, head 6) → only request 6 is emitted, with out_first=out_last=1.
- Loop guard, MAX_HOPS=4: entries 0→1→0 loop → exactly 4 entries visited; done and err_loop pulse together; busy=0 next cycle.
- Abort and reset: abort during LINK → IDLE next cycle with no done; a start 1 cycle later walks normally. rst asserted mid-EMIT → all outputs 0 on the next edge.
